// File: rtl/cnu_pkg.sv
// Shared types and defaults for the serial min-sum check-node unit.
package cnu_pkg;

    localparam int DC_DEF     = 6;
    localparam int W_DEF      = 6;
    localparam int OFFSET_DEF = 1;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_e;

    // Sign-magnitude message at the default width; cnu_serial builds its own at W.
    typedef struct packed {
        logic             sign;
        logic [W_DEF-2:0] mag;
    } msg_t;

endpackage

// File: rtl/cnu_min_tracker.sv
// Running min1/min2/argmin tracker with per-frame clear.
module cnu_min_tracker #(
    parameter int MW = 5,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          upd_i,
    input  logic [MW-1:0] mag_i,
    input  logic [IW-1:0] idx_i,
    output logic [MW-1:0] min1_o,
    output logic [MW-1:0] min2_o,
    output logic [IW-1:0] idx_o
);

    logic [MW-1:0] min1_q, min1_d;
    logic [MW-1:0] min2_q, min2_d;
    logic [IW-1:0] idx_q, idx_d;

    always_comb begin
        min1_d = min1_q;
        min2_d = min2_q;
        idx_d  = idx_q;
        if (clear_i) begin
            min1_d = '1;
            min2_d = '1;
            idx_d  = '0;
        end else if (upd_i) begin
            // strict compares send ties to min2
            if (mag_i < min1_q) begin
                min2_d = min1_q;
                min1_d = mag_i;
                idx_d  = idx_i;
            end else if (mag_i < min2_q) begin
                min2_d = mag_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min1_q <= '1;
            min2_q <= '1;
            idx_q  <= '0;
        end else begin
            min1_q <= min1_d;
            min2_q <= min2_d;
            idx_q  <= idx_d;
        end
    end

    assign min1_o = min1_q;
    assign min2_o = min2_q;
    assign idx_o  = idx_q;

endmodule

// File: rtl/cnu_serial.sv
// Serial min-sum check-node unit: collect DC messages, then emit DC replies.
// Define CNU_OFFSET_EN to build the offset min-sum variant.
module cnu_serial
    import cnu_pkg::*;
#(
    parameter int DC     = DC_DEF,
    parameter int W      = W_DEF,
    parameter int OFFSET = OFFSET_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_msg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_msg,
    output logic [$clog2(DC)-1:0] out_idx,
    output logic                  out_last,
    output logic                  out_parity
);

    localparam int IW = $clog2(DC);
    localparam int MW = W - 1;
    localparam logic [IW-1:0] LAST = IW'(DC - 1);
    localparam int OMAX = (1 << MW) - 1;
    localparam int OCLP = (OFFSET > OMAX) ? OMAX : ((OFFSET < 0) ? 0 : OFFSET);
    localparam logic [MW-1:0] OFFM = MW'(OCLP);

`ifdef CNU_OFFSET_EN
    localparam bit OFF_EN = 1'b1;
`else
    localparam bit OFF_EN = 1'b0;
`endif

    typedef struct packed {
        logic          sign;
        logic [MW-1:0] mag;
    } msg_w_t;

    state_e        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [DC-1:0] signs_q, signs_d;
    logic          sx_q, sx_d;

    logic          accept;
    logic          fire;
    logic          clear;
    logic          at_last;
    msg_w_t        in_w;
    msg_w_t        out_w;
    logic [MW-1:0] min1, min2, sel;
    logic [IW-1:0] min_idx;

    assign in_w    = msg_w_t'(in_msg);
    assign at_last = (cnt_q == LAST);
    assign accept  = (state_q == COLLECT) && in_valid;
    assign fire    = (state_q == EMIT) && out_ready;
    assign clear   = fire && at_last;

    cnu_min_tracker #(
        .MW (MW),
        .IW (IW)
    ) u_min (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .upd_i   (accept),
        .mag_i   (in_w.mag),
        .idx_i   (cnt_q),
        .min1_o  (min1),
        .min2_o  (min2),
        .idx_o   (min_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            signs_q <= '0;
            sx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            signs_q <= signs_d;
            sx_q    <= sx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (accept && at_last) state_d = EMIT;
            EMIT:    if (clear) state_d = COLLECT;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        signs_d = signs_q;
        sx_d    = sx_q;
        if (accept) begin
            signs_d[cnt_q] = in_w.sign;
            sx_d           = sx_q ^ in_w.sign;
            cnt_d          = at_last ? '0 : cnt_q + 1'b1;
        end else if (fire) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
            if (clear) begin
                signs_d = '0;
                sx_d    = 1'b0;
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == COLLECT);
        out_valid = (state_q == EMIT);
        sel       = (cnt_q == min_idx) ? min2 : min1;
        out_w     = '0;
        out_w.mag = sel;
        if (OFF_EN) out_w.mag = (sel > OFFM) ? sel - OFFM : '0;
        out_w.sign = sx_q ^ signs_q[cnt_q];
        // outputs are forced to zero outside EMIT so reset/collect values are clean
        out_msg    = out_valid ? W'(out_w) : '0;
        out_idx    = out_valid ? cnt_q : '0;
        out_last   = out_valid && at_last;
        out_parity = out_valid && sx_q;
    end

endmodule

// File: doc/cnu_serial.md
CNU_SERIAL -- requirements
Module: cnu_serial

Interface
REQ-001 Parameter DC, default 6: check-node degree, number of messages per frame, range 2..32.
REQ-002 Parameter W, default 6: message width in sign-magnitude; bit W-1 is the sign and bits W-2:0 are the magnitude.
REQ-003 Parameter OFFSET, default 1: offset subtracted from output magnitudes; used only when CNU_OFFSET_EN is defined.
REQ-004 Port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port in_valid, input, 1 bit: in_msg holds a valid variable-to-check message.
REQ-007 Port in_ready, output, 1 bit: the block accepts in_msg this cycle.
REQ-008 Port in_msg, input, W bits: incoming message, sign-magnitude.
REQ-009 Port out_valid, output, 1 bit: out_msg, out_idx, out_last and out_parity are valid.
REQ-010 Port out_ready, input, 1 bit: downstream accepts the output this cycle.
REQ-011 Port out_msg, output, W bits: check-to-variable message, sign-magnitude.
REQ-012 Port out_idx, output, $clog2(DC) bits: edge index of out_msg.
REQ-013 Port out_last, output, 1 bit: asserted with edge index DC-1.
REQ-014 Port out_parity, output, 1 bit: XOR of all DC input signs; 0 means the check is satisfied.

Function
REQ-015 The FSM SHALL have two states.
- COLLECT: in_ready=1, out_valid=0.
- EMIT: in_ready=0, out_valid=1.
REQ-016 In COLLECT, each in_valid cycle accepts one message at edge index cnt (0..DC-1), then increments cnt.
REQ-017 Each accepted message SHALL update the running state: min1, min2, min1 index, the sign XOR, and a stored per-edge sign bit.
REQ-018 Min update rule:
- If mag < min1: min2 takes min1, min1 takes mag, and the index is recorded.
- Else if mag < min2: min2 takes mag.
- Ties therefore go to min2.
REQ-019 min1 and min2 SHALL start each frame at all-ones, i.e. 2^(W-1)-1.
REQ-020 When message DC-1 is accepted, the FSM SHALL enter EMIT on the next cycle with cnt=0, so the first output appears 1 cycle after the last input.
REQ-021 Output magnitude SHALL be min2 when out_idx equals the min1 index, and min1 otherwise.
REQ-022 Output sign SHALL be the frame sign XOR the stored sign of that edge.
REQ-023 In EMIT, out_idx advances only on an out_valid&&out_ready cycle; while out_ready=0, all outputs hold stable.
REQ-024 After the handshake on out_last, the block SHALL return to COLLECT and clear all frame state on the next cycle; input and output frames do not overlap.
REQ-025 in_valid is ignored in EMIT; out_ready is ignored in COLLECT.

Reset
REQ-026 When rst_n=0 at a clock edge, the block SHALL return to COLLECT.
- cnt=0, min1 and min2 all-ones, sign XOR 0.
- out_valid=0, out_msg=0, out_idx=0, out_last=0, out_parity=0.
REQ-027 A reset in either state SHALL discard the partial frame entirely; the first accepted message after reset is edge 0.

Configuration
REQ-028 With CNU_OFFSET_EN defined, the output magnitude SHALL be max(selected_min - OFFSET, 0), saturating at 0 with no wrap.
REQ-029 Without CNU_OFFSET_EN, the block SHALL implement plain min-sum, and OFFSET has no effect.

Structure
REQ-030 Package cnu_pkg SHALL hold:
- the state enum {COLLECT, EMIT};
- default constants for DC, W and OFFSET;
- a sign-magnitude message typedef, parameterised by W.
REQ-031 Sub-module cnu_min_tracker SHALL hold the registered min1/min2/index update with a per-frame clear input; cnu_serial instantiates it once.

Verification
REQ-032 Basic frame, DC=6, W=6, with (sign,mag) inputs (0,5),(1,3),(0,7),(0,2),(0,9),(0,4) -> outputs:
- magnitudes 2,2,2,3,2,2;
- signs 1,0,1,1,1,1;
- out_parity=1; out_last with idx 5.
REQ-033 Tie case, all inputs (0,4) -> all magnitudes 4, all signs 0, out_parity=0.
REQ-034 Backpressure: hold out_ready=0 for 3 cycles at idx 2 -> out_msg and out_idx stable, in_ready=0 throughout; the frame completes normally afterwards.
REQ-035 Mid-frame reset: rst_n=0 for 1 cycle after 3 accepted inputs -> in_ready=1, out_valid=0; the next 6 inputs (REQ-032 vector) reproduce the REQ-032 outputs exactly.
REQ-036 Offset build: with CNU_OFFSET_EN and OFFSET=1, the REQ-032 vector -> magnitudes 1,1,1,2,1,1; a frame with min1=0 -> magnitude 0, no wrap.
REQ-037 Back-to-back frames: in_valid held high continuously -> the second frame is accepted starting the cycle after the first frame's out_last handshake, with no state carry-over.
